xor_quad_arbiter: RTL and testbench
===================================

# xor_quad_arbiter

Round-robin arbiter that shares one physical 74x86 quad 2-input XOR package (four gates) between several requesters. It latches the winning requester's 4-bit operands onto the package pins, waits a programmable settle time for TTL propagation, captures the package outputs and returns them with a one-cycle acknowledge. It sits between the netlist logic that needs XOR results and the single 74x86 in the board-level design.

## Interface
- `N_REQ`, default 4: number of requesters; valid range 2..8.
- `SETTLE`, default 2: clock cycles the package inputs are held before `GATE_Y` is sampled; minimum 1.
- `CLK`  in  1: single system clock; all state changes on the rising edge.
- `RST`  in  1: reset, asynchronous and active-high.
- `REQ`  in  N_REQ: per-requester request level.
- `A_IN`  in  4*N_REQ: operand A; requester i owns bits [4i+3:4i].
- `B_IN`  in  4*N_REQ: operand B, same packing as `A_IN`.
- `GATE_A`  out  4: to 74x86 A pins (gates 1..4 = bits 0..3).
- `GATE_B`  out  4: to 74x86 B pins.
- `GATE_Y`  in  4: from 74x86 Y pins.
- `Y_OUT`  out  4: captured result.
- `ACK`  out  N_REQ: one-hot acknowledge, valid with `Y_OUT`.
- `GNT`  out  N_REQ: one-hot current owner.
- `BUSY`  out  1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: no owner.
  - DRIVE: operands on the package pins, counting down the settle time.
  - RESP: result returned to the owner.
- Reset values:
  - State IDLE.
  - `GATE_A`, `GATE_B`, `Y_OUT`, `ACK` and `GNT` all 0.
  - `BUSY` 0.
  - Internal count 0.
  - Last-grant pointer = N_REQ-1, so requester 0 has top priority first.
- IDLE, `REQ` nonzero:
  - Pick the first set bit searching from last+1 upward, wrapping modulo N_REQ.
  - On the same edge: latch that requester's operand slices into `GATE_A`/`GATE_B`, set `GNT` one-hot, update the last pointer, load count = SETTLE-1, go to DRIVE.
- IDLE, `REQ` zero: hold everything.
- DRIVE, count > 0: decrement the count.
- DRIVE, count == 0:
  - `Y_OUT` <= `GATE_Y`.
  - `ACK` <= `GNT`.
  - Go to RESP.
- RESP: on the next edge `ACK` <= 0, `GNT` <= 0, go to IDLE.
- Operands are sampled only at the grant edge. Changes on `A_IN`/`B_IN` after that edge do not affect the current operation.
- A requester that drops `REQ` during DRIVE still receives its `ACK`. The operation is never aborted except by `RST`.
- A requester must deassert `REQ` on the edge that ends its `ACK` cycle. Any `REQ` seen in IDLE is treated as a new request.
- `GATE_A`/`GATE_B` hold their last operands after an operation; they are not cleared. `Y_OUT` holds until the next capture.
- `RST` mid-operation:
  - Immediate return to reset values.
  - No `ACK` is produced.
  - The pending requester must re-request.

## Timing
- The grant edge is edge 0.
- `GATE_A`/`GATE_B` are valid from edge 0.
- `GATE_Y` is sampled at edge SETTLE.
- `ACK` and `Y_OUT` are valid for exactly one cycle, between edge SETTLE and edge SETTLE+1.
- State is IDLE again after edge SETTLE+1.
- The next grant is at edge SETTLE+2 at the earliest. Throughput is one operation per SETTLE+2 cycles.
- With SETTLE=1, DRIVE lasts one cycle and `ACK` is high between edges 1 and 2.
- `BUSY` is high from edge 0 to edge SETTLE+1.
- `GNT` has the same span as `BUSY`.
- All outputs are registered. There is no combinational path from `REQ`, `A_IN`, `B_IN` or `GATE_Y` to any output.

## Test plan
Bench configuration: N_REQ=4, SETTLE=2, and a behavioural 74x86 model with `GATE_Y` = `GATE_A` ^ `GATE_B` after 1 cycle of delay.

- Single request: `REQ`=0001, A slice=4'hA, B slice=4'h6 -> `GATE_A`=A, `GATE_B`=6 after the grant edge; `ACK`=0001 and `Y_OUT`=4'hC for one cycle, 2 edges after the grant; `BUSY` low after 3 edges.
- Simultaneous requests: `REQ`=1111 held high, dropped per ACK -> grant order 0,1,2,3; each `Y_OUT` matches that requester's XOR; one grant every 4 cycles.
- Fairness under contention: requesters 0 and 2 held permanently high (re-requesting after each ACK) -> grants alternate 0,2,0,2; neither requester is starved.
- Operand change after grant: requester 1 with A=4'hF, B=4'h0, then A changed to 4'h3 one cycle after the grant -> `Y_OUT`=4'hF.
- Reset mid-DRIVE: assert `RST` one cycle after the grant -> all outputs 0 immediately, no `ACK`; after release, the held `REQ`=0100 is granted and completes normally.
- SETTLE=1 build: `REQ`=1000, A=4'h5, B=4'h5 -> `ACK`=1000 and `Y_OUT`=4'h0 one edge after the grant.

Source files
------------

// File: rtl/xor_quad_arbiter.sv
// xor_quad_arbiter
// Round-robin arbiter that shares one 74x86 quad 2-input XOR package among
// N_REQ requesters. The winner's 4-bit operands are latched onto the package
// pins, held for SETTLE cycles of TTL propagation, and then the package
// outputs are captured and returned with a one-cycle one-hot ACK.
//
// Ports
//   CLK     system clock, rising edge
//   RST     asynchronous active-high reset
//   REQ     per-requester request level
//   A_IN    operand A, requester i owns bits [4i+3:4i]
//   B_IN    operand B, same packing
//   GATE_A  to package A pins (gate 1..4 = bit 0..3)
//   GATE_B  to package B pins
//   GATE_Y  from package Y pins
//   Y_OUT   captured result, valid with ACK
//   ACK     one-hot acknowledge, one cycle
//   GNT     one-hot current owner
//   BUSY    high whenever the FSM is not IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; grant the next requester round-robin
// DRIVE | operands on the package pins, count down the settle time
// RESP  | result and ACK presented to the owner for one cycle
module xor_quad_arbiter #(
    parameter int N_REQ  = 4,
    parameter int SETTLE = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [4*N_REQ-1:0] A_IN,
    input  logic [4*N_REQ-1:0] B_IN,
    output logic [3:0]         GATE_A,
    output logic [3:0]         GATE_B,
    input  logic [3:0]         GATE_Y,
    output logic [3:0]         Y_OUT,
    output logic [N_REQ-1:0]   ACK,
    output logic [N_REQ-1:0]   GNT,
    output logic               BUSY
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      last_q, last_d;
    logic [3:0]         gate_a_q, gate_a_d;
    logic [3:0]         gate_b_q, gate_b_d;
    logic [3:0]         y_q, y_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;

    logic               found;
    int                 pick;
    int                 idx;

    // Search upward from the slot after the last grant, wrapping, so the
    // most recently served requester has the lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = 0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_q) + k) % N_REQ;
            if (!found && REQ[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gate_a_d = gate_a_q;
        gate_b_d = gate_b_q;
        y_d      = y_q;
        ack_d    = ack_q;
        gnt_d    = gnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gate_a_d    = A_IN[4*pick +: 4];
                    gate_b_d    = B_IN[4*pick +: 4];
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    last_d      = pick[PW-1:0];
                    cnt_d       = CW'(SETTLE - 1);
                    state_d     = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    y_d     = GATE_Y;
                    ack_d   = gnt_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                ack_d   = '0;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= PW'(N_REQ - 1);
            gate_a_q <= '0;
            gate_b_q <= '0;
            y_q      <= '0;
            ack_q    <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gate_a_q <= gate_a_d;
            gate_b_q <= gate_b_d;
            y_q      <= y_d;
            ack_q    <= ack_d;
            gnt_q    <= gnt_d;
        end
    end

    assign GATE_A = gate_a_q;
    assign GATE_B = gate_b_q;
    assign Y_OUT  = y_q;
    assign ACK    = ack_q;
    assign GNT    = gnt_q;
    assign BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_xor_quad_arbiter.sv
module tb_xor_quad_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;

    logic [N-1:0]   req;
    logic [4*N-1:0] a_in, b_in;
    logic [3:0]     gate_a, gate_b;
    logic [3:0]     gate_y = 4'h0;
    logic [3:0]     y_out;
    logic [N-1:0]   ack, gnt;
    logic           busy;

    logic [N-1:0]   req_s1;
    logic [4*N-1:0] a_in_s1, b_in_s1;
    logic [3:0]     gate_a_s1, gate_b_s1, gate_y_s1, y_out_s1;
    logic [N-1:0]   ack_s1, gnt_s1;
    logic           busy_s1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // 74x86 model for the SETTLE=2 build: one cycle of propagation delay.
    always @(posedge clk) gate_y <= gate_a ^ gate_b;
    // SETTLE=1 build: package settles within the cycle.
    assign gate_y_s1 = gate_a_s1 ^ gate_b_s1;

    xor_quad_arbiter #(.N_REQ(N), .SETTLE(2)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .A_IN(a_in), .B_IN(b_in),
        .GATE_A(gate_a), .GATE_B(gate_b), .GATE_Y(gate_y), .Y_OUT(y_out),
        .ACK(ack), .GNT(gnt), .BUSY(busy)
    );

    xor_quad_arbiter #(.N_REQ(N), .SETTLE(1)) dut_s1 (
        .CLK(clk), .RST(rst), .REQ(req_s1), .A_IN(a_in_s1), .B_IN(b_in_s1),
        .GATE_A(gate_a_s1), .GATE_B(gate_b_s1), .GATE_Y(gate_y_s1), .Y_OUT(y_out_s1),
        .ACK(ack_s1), .GNT(gnt_s1), .BUSY(busy_s1)
    );

    typedef struct {
        int         r;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full SETTLE=2 operation starting with the grant edge.
    task automatic do_op(input string name, input int r, input logic [3:0] exp_y,
                         input logic [3:0] exp_a, input logic [3:0] exp_b, input bit drop);
        logic [N-1:0] oh;
        oh = '0;
        oh[r] = 1'b1;
        step();
        chk({name, " gnt"}, 32'(gnt), 32'(oh));
        chk({name, " busy0"}, 32'(busy), 32'd1);
        chk({name, " gate_a"}, 32'(gate_a), 32'(exp_a));
        chk({name, " gate_b"}, 32'(gate_b), 32'(exp_b));
        step();
        chk({name, " ack_early"}, 32'(ack), 32'd0);
        step();
        chk({name, " ack"}, 32'(ack), 32'(oh));
        chk({name, " y_out"}, 32'(y_out), 32'(exp_y));
        if (drop) req[r] = 1'b0;
        step();
        chk({name, " ack_end"}, 32'(ack), 32'd0);
        chk({name, " busy_end"}, 32'(busy), 32'd0);
        chk({name, " gnt_end"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        vecs[0] = '{r: 0, a: 4'hA, b: 4'h6, y: 4'hC};
        vecs[1] = '{r: 1, a: 4'hF, b: 4'h0, y: 4'hF};
        vecs[2] = '{r: 2, a: 4'h3, b: 4'h5, y: 4'h6};
        vecs[3] = '{r: 3, a: 4'h9, b: 4'h9, y: 4'h0};
        vecs[4] = '{r: 0, a: 4'h0, b: 4'hF, y: 4'hF};
        vecs[5] = '{r: 2, a: 4'h5, b: 4'hA, y: 4'hF};

        rst = 1'b1;
        req = '0; a_in = '0; b_in = '0;
        req_s1 = '0; a_in_s1 = '0; b_in_s1 = '0;
        step();
        step();
        chk("rst gate_a", 32'(gate_a), 32'd0);
        chk("rst gate_b", 32'(gate_b), 32'd0);
        chk("rst y_out", 32'(y_out), 32'd0);
        chk("rst ack", 32'(ack), 32'd0);
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        chk("idle hold busy", 32'(busy), 32'd0);

        // Single requests from the table.
        for (int i = 0; i < 6; i++) begin
            a_in = 16'h7777;
            b_in = 16'h2222;
            a_in[4*vecs[i].r +: 4] = vecs[i].a;
            b_in[4*vecs[i].r +: 4] = vecs[i].b;
            req = '0;
            req[vecs[i].r] = 1'b1;
            do_op($sformatf("vec%0d", i), vecs[i].r, vecs[i].y, vecs[i].a, vecs[i].b, 1'b1);
        end

        // Simultaneous requests after reset: order 0,1,2,3, back to back.
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        a_in = {4'hB, 4'hC, 4'h7, 4'h1};
        b_in = {4'hB, 4'h4, 4'h2, 4'hE};
        req = 4'b1111;
        do_op("all r0", 0, 4'hF, 4'h1, 4'hE, 1'b1);
        do_op("all r1", 1, 4'h5, 4'h7, 4'h2, 1'b1);
        do_op("all r2", 2, 4'h8, 4'hC, 4'h4, 1'b1);
        do_op("all r3", 3, 4'h0, 4'hB, 4'hB, 1'b1);
        step();
        chk("all drained busy", 32'(busy), 32'd0);

        // Fairness: 0 and 2 held high must alternate.
        a_in = {4'h0, 4'h8, 4'h0, 4'h3};
        b_in = {4'h0, 4'h1, 4'h0, 4'h1};
        req = 4'b0101;
        do_op("fair a0", 0, 4'h2, 4'h3, 4'h1, 1'b0);
        do_op("fair a2", 2, 4'h9, 4'h8, 4'h1, 1'b0);
        do_op("fair b0", 0, 4'h2, 4'h3, 4'h1, 1'b0);
        do_op("fair b2", 2, 4'h9, 4'h8, 4'h1, 1'b0);
        req = '0;
        step();

        // Operands sampled only at the grant edge; REQ dropped mid-DRIVE.
        a_in = '0; b_in = '0;
        a_in[7:4] = 4'hF;
        b_in[7:4] = 4'h0;
        req = 4'b0010;
        step();
        chk("opchg gnt", 32'(gnt), 32'h2);
        req = '0;
        step();
        a_in[7:4] = 4'h3;
        step();
        chk("opchg ack", 32'(ack), 32'h2);
        chk("opchg y_out", 32'(y_out), 32'hF);
        chk("opchg gate_a held", 32'(gate_a), 32'hF);
        step();
        chk("opchg busy_end", 32'(busy), 32'd0);
        chk("opchg gate_a keep", 32'(gate_a), 32'hF);
        chk("opchg y_out keep", 32'(y_out), 32'hF);

        // Reset during DRIVE.
        a_in[11:8] = 4'h6;
        b_in[11:8] = 4'h3;
        req = 4'b0100;
        step();
        chk("rstmid gnt", 32'(gnt), 32'h4);
        rst = 1'b1;
        #1;
        chk("rstmid gnt0", 32'(gnt), 32'd0);
        chk("rstmid busy0", 32'(busy), 32'd0);
        chk("rstmid gate_a0", 32'(gate_a), 32'd0);
        chk("rstmid gate_b0", 32'(gate_b), 32'd0);
        chk("rstmid y0", 32'(y_out), 32'd0);
        step();
        chk("rstmid noack", 32'(ack), 32'd0);
        rst = 1'b0;
        do_op("rstmid regrant", 2, 4'h5, 4'h6, 4'h3, 1'b1);

        // SETTLE=1 build.
        a_in_s1 = '0; b_in_s1 = '0;
        a_in_s1[15:12] = 4'h5;
        b_in_s1[15:12] = 4'h5;
        req_s1 = 4'b1000;
        step();
        chk("s1 gnt", 32'(gnt_s1), 32'h8);
        chk("s1 ack_early", 32'(ack_s1), 32'd0);
        step();
        chk("s1 ack", 32'(ack_s1), 32'h8);
        chk("s1 y_out", 32'(y_out_s1), 32'h0);
        req_s1 = '0;
        step();
        chk("s1 ack_end", 32'(ack_s1), 32'd0);
        chk("s1 busy_end", 32'(busy_s1), 32'd0);
        a_in_s1[3:0] = 4'h3;
        b_in_s1[3:0] = 4'hC;
        req_s1 = 4'b0001;
        step();
        chk("s1b gnt", 32'(gnt_s1), 32'h1);
        step();
        chk("s1b ack", 32'(ack_s1), 32'h1);
        chk("s1b y_out", 32'(y_out_s1), 32'hF);
        req_s1 = '0;
        step();
        chk("s1b busy_end", 32'(busy_s1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
